// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative shifts (one bit per clock) and an
// optional iterative shift-add multiplier on opcode 3'b111.
// Build option: define ALU_SEQ_MUL_EN for the multiplier; otherwise 3'b111 is XOR.
// Results and flags are written only on completion, flagged by a one-cycle DONE.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] MUL_LD = (SHW+1)'(WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_SHL = 3'b010, OP_SHR = 3'b011,
        OP_ASR = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_MX  = 3'b111
    } op_e;

    state_e           r_state, w_state_nx;
    op_e              r_op, w_in_op, w_s_op;
    logic [WIDTH-1:0] r_work, w_s_work, w_st_work;
    logic [SHW:0]     r_cnt, w_cnt_ld;
    logic [SHW-1:0]   w_k;
    logic [WIDTH:0]   w_add, w_sub;
    logic             w_st_c, w_fin, w_fin_c, w_fin_v, w_launch;
    logic [WIDTH-1:0] w_fin_y;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_hi, r_mcand, w_s_hi, w_s_mcand, w_st_hi;
    logic [WIDTH:0]   w_sum;
`endif

    assign w_in_op = op_e'(OP);
    assign w_k     = B[SHW-1:0];
    assign w_add   = {1'b0, A} + {1'b0, B};
    assign w_sub   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign BUSY    = (r_state == ST_RUN);

    // The first iteration runs on the live inputs during the accept edge, so
    // an op of latency L needs only L-1 clocks in RUN.
    assign w_s_op   = (r_state == ST_IDLE) ? w_in_op : r_op;
    assign w_s_work = (r_state == ST_IDLE) ? ((w_in_op == OP_MX) ? B : A) : r_work;
`ifdef ALU_SEQ_MUL_EN
    assign w_s_hi    = (r_state == ST_IDLE) ? '0 : r_hi;
    assign w_s_mcand = (r_state == ST_IDLE) ? A  : r_mcand;
`endif

    // One iteration: a single-bit shift, or one partial product of {hi,lo}.
    always_comb begin
        w_st_work = w_s_work;
        w_st_c    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_st_hi = w_s_hi;
        w_sum   = {1'b0, w_s_hi} + (w_s_work[0] ? {1'b0, w_s_mcand} : '0);
`endif
        case (w_s_op)
            OP_SHL: begin
                w_st_work = {w_s_work[WIDTH-2:0], 1'b0};
                w_st_c    = w_s_work[WIDTH-1];
            end
            OP_SHR: begin
                w_st_work = {1'b0, w_s_work[WIDTH-1:1]};
                w_st_c    = w_s_work[0];
            end
            OP_ASR: begin
                w_st_work = {w_s_work[WIDTH-1], w_s_work[WIDTH-1:1]};
                w_st_c    = w_s_work[0];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MX: begin
                w_st_work = {w_sum[0], w_s_work[WIDTH-1:1]};
                w_st_hi   = w_sum[WIDTH:1];
            end
`endif
            default: ;
        endcase
    end

    // Next-state and completion decode.
    always_comb begin
        w_state_nx = r_state;
        w_fin      = 1'b0;
        w_fin_y    = w_st_work;
        w_fin_c    = w_st_c;
        w_fin_v    = 1'b0;
        w_launch   = 1'b0;
        w_cnt_ld   = {1'b0, w_k} - (SHW+1)'(1);
        if (r_state == ST_IDLE) begin
            if (START) begin
                case (w_in_op)
                    OP_ADD: begin
                        w_fin   = 1'b1;
                        w_fin_y = w_add[WIDTH-1:0];
                        w_fin_c = w_add[WIDTH];
                        w_fin_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
                    end
                    OP_SUB: begin
                        w_fin   = 1'b1;
                        w_fin_y = w_sub[WIDTH-1:0];
                        w_fin_c = w_sub[WIDTH];
                        w_fin_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
                    end
                    OP_AND: begin
                        w_fin   = 1'b1;
                        w_fin_y = A & B;
                        w_fin_c = 1'b0;
                    end
                    OP_OR: begin
                        w_fin   = 1'b1;
                        w_fin_y = A | B;
                        w_fin_c = 1'b0;
                    end
                    OP_SHL, OP_SHR, OP_ASR: begin
                        if (w_k == '0) begin
                            w_fin   = 1'b1;
                            w_fin_y = A;
                            w_fin_c = 1'b0;
                        end else if (w_k == SHW'(1)) begin
                            w_fin = 1'b1;
                        end else begin
                            w_launch   = 1'b1;
                            w_state_nx = ST_RUN;
                        end
                    end
                    default: begin
`ifdef ALU_SEQ_MUL_EN
                        w_launch   = 1'b1;
                        w_state_nx = ST_RUN;
                        w_cnt_ld   = MUL_LD;
`else
                        w_fin   = 1'b1;
                        w_fin_y = A ^ B;
                        w_fin_c = 1'b0;
`endif
                    end
                endcase
            end
        end else if (r_cnt == (SHW+1)'(1)) begin
            w_fin      = 1'b1;
            w_state_nx = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
            if (r_op == OP_MX) begin
                w_fin_c = |w_st_hi;
                w_fin_v = |w_st_hi;
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Result/flag registers and iteration working registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            DONE   <= 1'b0;
            Y      <= '0;
            C      <= 1'b0;
            V      <= 1'b0;
            N      <= 1'b0;
            Z      <= 1'b0;
            r_op   <= OP_ADD;
            r_work <= '0;
            r_cnt  <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_hi    <= '0;
            r_mcand <= '0;
`endif
        end else begin
            DONE <= w_fin;
            if (w_fin) begin
                Y <= w_fin_y;
                C <= w_fin_c;
                V <= w_fin_v;
                N <= w_fin_y[WIDTH-1];
                Z <= (w_fin_y == '0);
            end
            if (w_launch || BUSY) begin
                r_work <= w_st_work;
                r_cnt  <= w_launch ? w_cnt_ld : r_cnt - (SHW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
                r_hi <= w_st_hi;
`endif
            end
            if (w_launch) begin
                r_op <= w_in_op;
`ifdef ALU_SEQ_MUL_EN
                r_mcand <= A;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (WIDTH=8).
// Multiplier vectors apply when ALU_SEQ_MUL_EN is defined, XOR vectors otherwise.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       START = 1'b0;
    logic [2:0] OP = 3'b000;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       BUSY, DONE, C, V, N, Z;
    logic [7:0] Y;

    int errors = 0;
    int checks = 0;
    int lat, bsy;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .Y(Y), .C(C), .V(V), .N(N), .Z(Z)
    );

    always #5 clk = ~clk;

    // Single checker: counts every comparison and reports mismatches.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, wait for DONE.
    // lat = cycles from accept edge to DONE cycle, bsy = BUSY cycles seen.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int l, output int bc);
        @(negedge clk);
        START = 1'b1; OP = op; A = a; B = b;
        @(posedge clk); #1;
        START = 1'b0; A = 8'($urandom); B = 8'($urandom);
        l = 1; bc = 0;
        while (!DONE && l < 40) begin
            if (BUSY) bc++;
            @(posedge clk); #1;
            l++;
        end
        if (!DONE) check("done_timeout", 32'(DONE), 32'd1);
        check("busy_in_done_cycle", 32'(BUSY), 32'd0);
    endtask

    function automatic logic [3:0] flags();
        return {C, V, N, Z};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", 32'(Y), 32'h00);
        check("rst_flags", 32'(flags()), 32'h0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        @(negedge clk); reset = 1'b0;

        // ADD overflow into sign bit
        run_op(3'b000, 8'h7F, 8'h01, lat, bsy);
        check("add_lat", 32'(lat), 32'd1);
        check("add_busy", 32'(bsy), 32'd0);
        check("add_y", 32'(Y), 32'h80);
        check("add_cvnz", 32'(flags()), 32'b0110);

        // SUB then back-to-back AND issued in the DONE cycle
        run_op(3'b001, 8'h80, 8'h01, lat, bsy);
        check("sub_y", 32'(Y), 32'h7F);
        check("sub_cvnz", 32'(flags()), 32'b1100);
        run_op(3'b101, 8'hF0, 8'h0F, lat, bsy);
        check("and_lat", 32'(lat), 32'd1);
        check("and_y", 32'(Y), 32'h00);
        check("and_cvnz", 32'(flags()), 32'b0001);

        // ADD carry wrap to zero
        run_op(3'b000, 8'hFF, 8'h01, lat, bsy);
        check("addw_y", 32'(Y), 32'h00);
        check("addw_cvnz", 32'(flags()), 32'b1001);

        // SHL 0xA1 by 3 with a START attempted while BUSY
        @(negedge clk);
        START = 1'b1; OP = 3'b010; A = 8'hA1; B = 8'h03;
        @(posedge clk); #1;
        START = 1'b0;
        check("shl_busy_t1", 32'(BUSY), 32'd1);
        check("shl_done_t1", 32'(DONE), 32'd0);
        @(negedge clk);
        START = 1'b1; OP = 3'b000; A = 8'h01; B = 8'h01;
        @(posedge clk); #1;
        START = 1'b0;
        check("shl_busy_t2", 32'(BUSY), 32'd1);
        check("shl_done_t2", 32'(DONE), 32'd0);
        check("shl_y_hold", 32'(Y), 32'h00);
        @(posedge clk); #1;
        check("shl_done_t3", 32'(DONE), 32'd1);
        check("shl_busy_t3", 32'(BUSY), 32'd0);
        check("shl_y", 32'(Y), 32'h08);
        check("shl_cvnz", 32'(flags()), 32'b1000);
        @(posedge clk); #1;
        check("shl_noqueue_done", 32'(DONE), 32'd0);
        check("shl_noqueue_y", 32'(Y), 32'h08);

        // ASR 0x90 by 2
        run_op(3'b100, 8'h90, 8'h02, lat, bsy);
        check("asr_lat", 32'(lat), 32'd2);
        check("asr_busy", 32'(bsy), 32'd1);
        check("asr_y", 32'(Y), 32'hE4);
        check("asr_cvnz", 32'(flags()), 32'b0010);

        // Shift boundaries: k=1, k=0 (upper B bits ignored), k=7
        run_op(3'b011, 8'h81, 8'h01, lat, bsy);
        check("shr1_lat", 32'(lat), 32'd1);
        check("shr1_y", 32'(Y), 32'h40);
        check("shr1_cvnz", 32'(flags()), 32'b1000);
        run_op(3'b010, 8'hD5, 8'h08, lat, bsy);
        check("shl0_lat", 32'(lat), 32'd1);
        check("shl0_y", 32'(Y), 32'hD5);
        check("shl0_cvnz", 32'(flags()), 32'b0010);
        run_op(3'b011, 8'h80, 8'h07, lat, bsy);
        check("shr7_lat", 32'(lat), 32'd7);
        check("shr7_busy", 32'(bsy), 32'd6);
        check("shr7_y", 32'(Y), 32'h01);
        check("shr7_cvnz", 32'(flags()), 32'b0000);
        run_op(3'b100, 8'hC0, 8'h07, lat, bsy);
        check("asr7_y", 32'(Y), 32'hFF);
        check("asr7_cvnz", 32'(flags()), 32'b1010);

        // OR of zeros
        run_op(3'b110, 8'h00, 8'h00, lat, bsy);
        check("or_y", 32'(Y), 32'h00);
        check("or_cvnz", 32'(flags()), 32'b0001);
        run_op(3'b110, 8'h81, 8'h30, lat, bsy);
        check("or2_y", 32'(Y), 32'hB1);

`ifdef ALU_SEQ_MUL_EN
        run_op(3'b111, 8'h0F, 8'h11, lat, bsy);
        check("mul_lat", 32'(lat), 32'd8);
        check("mul_busy", 32'(bsy), 32'd7);
        check("mul_y", 32'(Y), 32'hFF);
        check("mul_cvnz", 32'(flags()), 32'b0010);
        run_op(3'b111, 8'h10, 8'h10, lat, bsy);
        check("mul_ovf_y", 32'(Y), 32'h00);
        check("mul_ovf_cvnz", 32'(flags()), 32'b1101);
        run_op(3'b111, 8'hFF, 8'hFF, lat, bsy);
        check("mul_max_y", 32'(Y), 32'h01);
        check("mul_max_cvnz", 32'(flags()), 32'b1100);
        run_op(3'b000, 8'h12, 8'h34, lat, bsy);
        check("pre_rst_y", 32'(Y), 32'h46);
        // long op to be aborted by reset
        @(negedge clk);
        START = 1'b1; OP = 3'b111; A = 8'h0F; B = 8'h11;
`else
        run_op(3'b111, 8'hF0, 8'h3C, lat, bsy);
        check("xor_lat", 32'(lat), 32'd1);
        check("xor_busy", 32'(bsy), 32'd0);
        check("xor_y", 32'(Y), 32'hCC);
        check("xor_cvnz", 32'(flags()), 32'b0010);
        run_op(3'b000, 8'h12, 8'h34, lat, bsy);
        check("pre_rst_y", 32'(Y), 32'h46);
        // long op to be aborted by reset
        @(negedge clk);
        START = 1'b1; OP = 3'b010; A = 8'hFF; B = 8'h07;
`endif
        @(posedge clk); #1;
        START = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("abort_busy", 32'(BUSY), 32'd1);
            check("abort_nodone", 32'(DONE), 32'd0);
            @(posedge clk); #1;
        end
        // cycle t+4: reset together with a new START
        reset = 1'b1; START = 1'b1; OP = 3'b000; A = 8'h03; B = 8'h03;
        @(posedge clk); #1;
        reset = 1'b0; START = 1'b0;
        check("abort_rst_done", 32'(DONE), 32'd0);
        check("abort_rst_busy", 32'(BUSY), 32'd0);
        check("abort_rst_y", 32'(Y), 32'h00);
        check("abort_rst_flags", 32'(flags()), 32'h0);
        @(posedge clk); #1;
        check("abort_drop_done", 32'(DONE), 32'd0);
        check("abort_drop_y", 32'(Y), 32'h00);
        run_op(3'b000, 8'h01, 8'h01, lat, bsy);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_y", 32'(Y), 32'h02);
        check("post_rst_cvnz", 32'(flags()), 32'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the processor's 8-bit combinational ALU. It executes one operation per START request and registers the result and the C/V/N/Z flags. Multi-bit shifts and the optional multiply run iteratively, one step per clock, and the block reports completion through a BUSY/DONE handshake. It sits between the register file and the writeback mux; the datapath controller stalls the processor while BUSY is high.

## Interface
- WIDTH, 8: operand/result width; power of two, ≥4.
- SHW, $clog2(WIDTH): derived shift-amount width; not overridable.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- START  in  1  request; accepted on a rising edge when BUSY=0 and reset=0.
- OP  in  3  opcode, sampled at accept.
- A  in  WIDTH  operand A, sampled at accept.
- B  in  WIDTH  operand B, sampled at accept; B[SHW-1:0] is the shift amount for shifts.
- BUSY  out  1  operation in progress; START is ignored while high.
- DONE  out  1  one-cycle pulse: Y and flags are updated.
- Y  out  WIDTH  result; holds until the next completion.
- C, V, N, Z  out  1 each  carry, overflow, negative, zero; hold with Y.

## Operation
- OP decode:
  - 000 ADD: Y=A+B. C=carry out. V=signed overflow.
  - 001 SUB: Y=A+~B+1. C=carry out (1 = no borrow). V=signed overflow.
  - 010 SHL: logical left shift by k=B[SHW-1:0].
  - 011 SHR: logical right shift by k.
  - 100 ASR: arithmetic right shift by k; MSB replicated.
  - 101 AND, 110 OR: V=0, C=0.
  - 111 MUL or XOR; see Configuration.
- Shifts:
  - One bit position per cycle, in an internal working register.
  - C = the last bit shifted out; V=0.
  - k=0: Y=A, C=0.
- Flags, all ops: N=Y[WIDTH-1]; Z=(Y==0).
- FSM:
  - IDLE to RUN on accept of a shift with k≥1, or of MUL.
  - IDLE to IDLE, writing Y/flags and pulsing DONE, on accept of any other op.
  - RUN: decrements an SHW+1-bit step counter. On counter 1, writes Y/flags, pulses DONE and returns to IDLE.
- Result and flags registers are written only at completion; partial values are never visible on Y.
- START while BUSY=1: ignored, no queueing, operands not resampled.
- Operand inputs may change freely after accept.

## Timing
- Accept at edge t; latency L; DONE=1 and new Y/flags are visible in cycle t+L.
  - ADD/SUB/AND/OR/XOR, and shifts with k=0: L=1.
  - Shifts with k≥1: L=k.
  - MUL: L=WIDTH.
- BUSY:
  - High in cycles t+1 .. t+L-1 and low in the DONE cycle.
  - L=1 ops never raise BUSY.
- Back-to-back: START may be asserted in the DONE cycle and is accepted at that edge; throughput is 1 op/clk for L=1 ops.
- Reset:
  - Y=0, C=V=N=Z=0, DONE=0, BUSY=0, FSM=IDLE.
  - Reset mid-operation aborts: no DONE, outputs cleared next cycle.
  - START and reset asserted together: reset wins, request dropped.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - OP 111 = unsigned shift-add multiply, one partial product per cycle.
  - Y = low WIDTH bits of the 2·WIDTH product.
  - C=V=1 iff the high half is nonzero.
- ALU_SEQ_MUL_EN undefined:
  - OP 111 = XOR, L=1, C=V=0.
  - No multiplier accumulator is synthesised.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 → DONE at t+1, BUSY never high; Y=0x80, N=1, V=1, C=0, Z=0.
- SUB 0x80−0x01 → Y=0x7F, C=1, V=1, N=0; then a back-to-back AND 0xF0,0x0F in the DONE cycle → Y=0x00, Z=1, C=V=0 one cycle later.
- SHL 0xA1 by 3:
  - BUSY high 2 cycles, DONE at t+3.
  - Y=0x08, C=1; a START during BUSY is ignored.
  - Also ASR 0x90 by 2 → Y=0xE4, N=1, C=0.
- MUL, macro defined:
  - 0x0F×0x11 → DONE at t+8, Y=0xFF, C=V=0, N=1.
  - 0x10×0x10 → Y=0x00, C=V=1, Z=1.
- MUL, macro undefined: 0xF0 op111 0x3C → Y=0xCC in 1 cycle, C=V=0.
- Reset at t+4 of a MUL → no DONE; next cycle Y=0, all flags 0, BUSY=0; a fresh ADD 0x01+0x01 → Y=0x02.
